alu_seq: RTL and testbench
==========================

# alu_seq

Registered, parametrised ALU with a start/done handshake and a multi-cycle unsigned multiplier. It generalises the 4-bit combinational ALU (add, sub, two's complement, logic ops, Z/C/S flags) to WIDTH bits and adds:
- an overflow flag,
- captured operands,
- a shift-add multiply mode producing a 2·WIDTH-bit product.

It sits between the operand/control source and the flag/result consumers of the datapath. Results are valid only while `done` is pulsed.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; ≥ 2.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request; sampled on a rising edge when `busy`=0.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `Op`  in  2  operation select.
- `L`  in  1  logic-group select.
- `M`  in  1  multiply mode; overrides `Op`/`L` when 1.
- `R`  out  WIDTH  result (low half of product in multiply).
- `RH`  out  WIDTH  high half of product; 0 for all other ops.
- `z`  out  1  zero flag.
- `c`  out  1  carry flag.
- `v`  out  1  signed-overflow flag.
- `s`  out  1  sign flag.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse; results and flags updated.

## Operation
- Operation groups:
  - `M`=0, `L`=0 (arithmetic, all via one adder X + Y + cin):
    - `Op`=00: A+B.
    - `Op`=01: A−B = A + ~B + 1.
    - `Op`=10: −A = 0 + ~A + 1.
    - `Op`=11: −B = 0 + ~B + 1.
  - `M`=0, `L`=1 (logic):
    - `Op`=00: A&B.
    - `Op`=01: A|B.
    - `Op`=10: A^B.
    - `Op`=11: ~A.
  - `M`=1: unsigned A×B; {RH,R} = 2·WIDTH-bit product.
- Flags, arithmetic group:
  - `c` = adder carry-out. For subtraction, `c`=1 means no borrow.
  - `v` = carry into MSB XOR carry out of MSB.
  - `s` = R[WIDTH−1].
  - `z` = (R==0).
- Flags, logic group:
  - `c`=0, `v`=0.
  - `s` = R[WIDTH−1].
  - `z` = (R==0).
- Flags, multiply:
  - `z` = ({RH,R}==0).
  - `c` = (RH≠0), i.e. product does not fit WIDTH bits.
  - `v`=0, `s`=0.
- `R`, `RH` and the flags are registers. They hold their last value until the next `done`.
- State machine:
  - IDLE: `start`=1 with `M`=0 → result/flags loaded, `done`=1 next cycle, stay IDLE. `start`=1 with `M`=1 → A, B captured, product accumulator cleared, iteration counter = 0, go to MUL, `busy`=1.
  - MUL: each edge examines one multiplier bit, LSB first: conditional add of the multiplicand, then shift right by one. After iteration WIDTH−1, load {RH,R} and the flags, `done`=1, `busy`=0, go to IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- A, B, `Op`, `L` and `M` changes during MUL have no effect.
- `start` held high in IDLE issues a new operation every cycle, with back-to-back `done` pulses.

## Timing
- Reset, asynchronous and immediate:
  - `R`, `RH` = 0.
  - `z`, `c`, `v`, `s`, `busy`, `done` = 0.
  - State = IDLE.
- Reset mid-multiply aborts the operation. No `done` is issued, and no partial result appears on `R`/`RH`.
- Single-cycle ops:
  - Sampled at edge k.
  - Results, flags and `done`=1 are visible after edge k.
  - `done` returns to 0 after edge k+1 unless a new start is sampled.
- Multiply:
  - Sampled at edge k; `busy`=1 after edge k.
  - Iterations occur at edges k+1 … k+WIDTH.
  - After edge k+WIDTH: results and flags valid, `done`=1, `busy`=0.
  - A new `start` is accepted at edge k+WIDTH+1 at the earliest, and `done` falls after that edge.
- `done` and `busy` are never high together.

## Test plan
- WIDTH=4, add: A=1010, B=1110, `Op`=00, `L`=0, `M`=0 → one cycle later R=1000, c=1, v=0, s=1, z=0, `done` pulse 1 cycle.
- WIDTH=4, subtract and negate:
  - A=1010, B=1010, `Op`=01 → R=0000, z=1, c=1, v=0.
  - Then B=1000, `Op`=11 → R=1000, v=1, s=1, c=0.
- WIDTH=4, logic, back-to-back with `start` held high:
  - xor 1010^1100 → 0110 in cycle 1.
  - ~A with A=1010 → 0101 in cycle 2.
  - `done` high both cycles; c=0, v=0 both cycles.
- WIDTH=4, multiply: A=1111, B=1111, `M`=1 → `busy` high exactly 4 cycles, then RH=1110, R=0001, c=1, z=0.
  - A second `start` during `busy` with different operands is ignored: exactly one `done`, same result.
- WIDTH=8, multiply: A=200, B=3 → RH=0x02, R=0x58 after 8 cycles.
  - Then A=0, B=0xFF → {RH,R}=0, z=1, c=0.
- Reset during MUL (edge k+2 of a WIDTH=4 multiply) → all outputs 0 immediately, no `done`.
  - The next `start` (A=0011, B=0101, `M`=1) completes normally: RH=0000, R=1111.

Source files
------------

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with a start/done handshake and a shift-add multiplier.
// Single-cycle ops take effect on the start edge; multiply takes WIDTH further edges.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Op,
    input  logic             L,
    input  logic             M,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] RH,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             s,
    output logic             busy,
    output logic             done
);

    // Handshake: start is accepted on any rising edge where busy is 0; done pulses
    // for exactly one cycle when R/RH/flags change, and is never high with busy.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     x_op;
    logic [WIDTH-1:0]     y_op;
    logic                 cin;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     low_sum;
    logic                 carry_msb;
    logic [WIDTH-1:0]     logic_res;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 last_iter;

    always_comb begin
        x_op = A;
        y_op = B;
        cin  = 1'b0;
        case (Op)
            2'b00: begin x_op = A;           y_op = B;  cin = 1'b0; end
            2'b01: begin x_op = A;           y_op = ~B; cin = 1'b1; end
            2'b10: begin x_op = '0;          y_op = ~A; cin = 1'b1; end
            default: begin x_op = '0;        y_op = ~B; cin = 1'b1; end
        endcase
    end

    assign sum       = {1'b0, x_op} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
    // A WIDTH-1 bit add of the low bits exposes the carry into the MSB for v.
    assign low_sum   = {1'b0, x_op[WIDTH-2:0]} + {1'b0, y_op[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
    assign carry_msb = low_sum[WIDTH-1];

    always_comb begin
        logic_res = A & B;
        case (Op)
            2'b00:   logic_res = A & B;
            2'b01:   logic_res = A | B;
            2'b10:   logic_res = A ^ B;
            default: logic_res = ~A;
        endcase
    end

    // prod holds {accumulator, remaining multiplier bits}; each step adds then shifts right.
    assign step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_next = {step_sum, prod[WIDTH-1:1]};
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            R     <= '0;
            RH    <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b0;
            s     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (M) begin
                            mcand <= A;
                            prod  <= {{WIDTH{1'b0}}, B};
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= MUL;
                        end else begin
                            done <= 1'b1;
                            RH   <= '0;
                            if (L) begin
                                R <= logic_res;
                                z <= (logic_res == '0);
                                c <= 1'b0;
                                v <= 1'b0;
                                s <= logic_res[WIDTH-1];
                            end else begin
                                R <= sum[WIDTH-1:0];
                                z <= (sum[WIDTH-1:0] == '0);
                                c <= sum[WIDTH];
                                v <= carry_msb ^ sum[WIDTH];
                                s <= sum[WIDTH-1];
                            end
                        end
                    end
                end
                MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        {RH, R} <= prod_next;
                        z       <= (prod_next == '0);
                        c       <= |prod_next[2*WIDTH-1:WIDTH];
                        v       <= 1'b0;
                        s       <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=4 and a WIDTH=8 instance checked every cycle against
// a cycle-counting arithmetic model, plus hand-computed literal checkpoints.
module tb_alu_seq;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] rh;
        logic       z;
        logic       c;
        logic       v;
        logic       s;
    } res_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // stimulus, index 0 = WIDTH 4, index 1 = WIDTH 8
    logic [1:0] st, l, m;
    logic [7:0] a [2];
    logic [7:0] b [2];
    logic [1:0] op [2];

    logic [3:0] r4, rh4;
    logic [7:0] r8, rh8;
    logic [1:0] zo, co, vo, so, bo, dn;
    logic [7:0] out_r [2];
    logic [7:0] out_rh [2];

    assign out_r[0]  = {4'b0, r4};
    assign out_rh[0] = {4'b0, rh4};
    assign out_r[1]  = r8;
    assign out_rh[1] = rh8;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(st[0]), .A(a[0][3:0]), .B(b[0][3:0]),
        .Op(op[0]), .L(l[0]), .M(m[0]), .R(r4), .RH(rh4),
        .z(zo[0]), .c(co[0]), .v(vo[0]), .s(so[0]), .busy(bo[0]), .done(dn[0])
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st[1]), .A(a[1]), .B(b[1]),
        .Op(op[1]), .L(l[1]), .M(m[1]), .R(r8), .RH(rh8),
        .z(zo[1]), .c(co[1]), .v(vo[1]), .s(so[1]), .busy(bo[1]), .done(dn[1])
    );

    int n_vec = 0;
    int n_err = 0;
    int ndone [2] = '{0, 0};

    // Reference arithmetic on plain integers.
    function automatic res_t model_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                                      input logic [1:0] opv, input logic lv, input logic mv);
        res_t o;
        int mask, ua, ub, sa, sb, x, res;
        o    = '0;
        mask = (1 << w) - 1;
        ua   = int'(av) & mask;
        ub   = int'(bv) & mask;
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        x    = 0;
        res  = 0;
        if (mv) begin
            x    = ua * ub;
            o.r  = 8'(x & mask);
            o.rh = 8'((x >> w) & mask);
            o.z  = (x == 0);
            o.c  = ((x >> w) != 0);
        end else if (lv) begin
            case (opv)
                2'd0:    x = ua & ub;
                2'd1:    x = ua | ub;
                2'd2:    x = ua ^ ub;
                default: x = (~ua) & mask;
            endcase
            o.r = 8'(x);
            o.s = 1'((x >> (w - 1)) & 1);
            o.z = (x == 0);
        end else begin
            case (opv)
                2'd0:    begin x = ua + ub; res = sa + sb; o.c = (x > mask);  end
                2'd1:    begin x = ua - ub; res = sa - sb; o.c = (ua >= ub);  end
                2'd2:    begin x = -ua;     res = -sa;     o.c = (ua == 0);   end
                default: begin x = -ub;     res = -sb;     o.c = (ub == 0);   end
            endcase
            o.r = 8'(x & mask);
            o.s = 1'(((x & mask) >> (w - 1)) & 1);
            o.z = ((x & mask) == 0);
            o.v = (res < -(1 << (w - 1))) || (res > (1 << (w - 1)) - 1);
        end
        return o;
    endfunction

    // Cycle model: cnt counts remaining multiply edges; results land when it hits 0.
    int   cnt [2];
    res_t ex [2];
    res_t pend [2];
    logic [1:0] ed;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i]  <= 0;
                ex[i]   <= '0;
                pend[i] <= '0;
            end
            ed <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ed[i] <= 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i] <= cnt[i] - 1;
                    if (cnt[i] == 1) begin
                        ex[i] <= pend[i];
                        ed[i] <= 1'b1;
                    end
                end else if (st[i]) begin
                    if (m[i]) begin
                        pend[i] <= model_op(i ? 8 : 4, a[i], b[i], op[i], l[i], m[i]);
                        cnt[i]  <= i ? 8 : 4;
                    end else begin
                        ex[i] <= model_op(i ? 8 : 4, a[i], b[i], op[i], l[i], m[i]);
                        ed[i] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[w%0d] @%0t: got %h, expected %h", nm, i ? 8 : 4, $time, act, exp);
        end
    endtask

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                check("r", i, out_r[i], ex[i].r);
                check("rh", i, out_rh[i], ex[i].rh);
                check("flags", i, {2'b0, zo[i], co[i], vo[i], so[i], bo[i], dn[i]},
                      {2'b0, ex[i].z, ex[i].c, ex[i].v, ex[i].s, (cnt[i] != 0), ed[i]});
                if (dn[i]) ndone[i]++;
            end
        end
    end

    // driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic sv, input logic [7:0] av, input logic [7:0] bv,
                         input logic [1:0] opv, input logic lv, input logic mv);
        st[i] = sv;
        a[i]  = av;
        b[i]  = bv;
        op[i] = opv;
        l[i]  = lv;
        m[i]  = mv;
    endtask

    // literal checkpoint on both the DUT and the model; f = {z,c,v,s,busy,done}
    task automatic pin(input string nm, input int i, input logic [7:0] er, input logic [7:0] erh,
                       input logic [5:0] f);
        check({nm, "_r"}, i, out_r[i], er);
        check({nm, "_rh"}, i, out_rh[i], erh);
        check({nm, "_flags"}, i, {2'b0, zo[i], co[i], vo[i], so[i], bo[i], dn[i]}, {2'b0, f});
        check({nm, "_model_r"}, i, ex[i].r, er);
        check({nm, "_model_flags"}, i, {4'b0, ex[i].z, ex[i].c, ex[i].v, ex[i].s},
              {4'b0, f[5:2]});
    endtask

    task automatic wait_done(input int i, input int max);
        int k = 0;
        while (!dn[i] && k < max) begin
            tick();
            k++;
        end
        check("done_timeout", i, {7'b0, dn[i]}, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b1;
        st    = 2'b00;
        l     = 2'b00;
        m     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            a[i]  = '0;
            b[i]  = '0;
            op[i] = '0;
        end
        #1;
        pin("reset4", 0, 8'h0, 8'h0, 6'b000000);
        pin("reset8", 1, 8'h0, 8'h0, 6'b000000);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // WIDTH=4 add
        drive(0, 1, 8'b1010, 8'b1110, 2'b00, 0, 0);
        tick();
        pin("add", 0, 8'b1000, 8'h0, 6'b010101);
        st[0] = 1'b0;
        tick();
        pin("add_hold", 0, 8'b1000, 8'h0, 6'b010100);

        // subtract to zero, then negate B = most negative
        drive(0, 1, 8'b1010, 8'b1010, 2'b01, 0, 0);
        tick();
        pin("sub", 0, 8'b0000, 8'h0, 6'b110001);
        drive(0, 1, 8'b1010, 8'b1000, 2'b11, 0, 0);
        tick();
        pin("negb", 0, 8'b1000, 8'h0, 6'b001101);

        // logic ops back-to-back with start held
        drive(0, 1, 8'b1010, 8'b1100, 2'b10, 1, 0);
        tick();
        pin("xor", 0, 8'b0110, 8'h0, 6'b000001);
        drive(0, 1, 8'b1010, 8'b1100, 2'b11, 1, 0);
        tick();
        pin("nota", 0, 8'b0101, 8'h0, 6'b000001);
        st[0] = 1'b0;
        tick();
        pin("nota_hold", 0, 8'b0101, 8'h0, 6'b000000);

        // 15*15 with an ignored second start while busy
        n0 = ndone[0];
        drive(0, 1, 8'b1111, 8'b1111, 2'b00, 0, 1);
        tick();
        pin("mul_k", 0, 8'b0101, 8'h0, 6'b000010);
        drive(0, 1, 8'b0011, 8'b0001, 2'b00, 0, 1);
        tick();
        pin("mul_k1", 0, 8'b0101, 8'h0, 6'b000010);
        tick();
        pin("mul_k2", 0, 8'b0101, 8'h0, 6'b000010);
        st[0] = 1'b0;
        tick();
        pin("mul_k3", 0, 8'b0101, 8'h0, 6'b000010);
        tick();
        pin("mul_done", 0, 8'b0001, 8'b1110, 6'b010001);
        repeat (3) tick();
        pin("mul_hold", 0, 8'b0001, 8'b1110, 6'b010000);
        check("mul_one_done", 0, 8'(ndone[0] - n0), 8'd1);

        // reset two edges into a multiply
        drive(0, 1, 8'b1111, 8'b1111, 2'b00, 0, 1);
        tick();
        st[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        pin("mid_reset", 0, 8'h0, 8'h0, 6'b000000);
        @(negedge clk);
        #1;
        reset = 1'b0;
        n0 = ndone[0];
        repeat (6) tick();
        check("no_done_after_reset", 0, 8'(ndone[0] - n0), 8'd0);
        pin("post_reset", 0, 8'h0, 8'h0, 6'b000000);
        drive(0, 1, 8'b0011, 8'b0101, 2'b00, 0, 1);
        tick();
        st[0] = 1'b0;
        wait_done(0, 10);
        pin("mul_3x5", 0, 8'b1111, 8'h0, 6'b000001);

        // WIDTH=8 multiply and signed boundaries
        drive(1, 1, 8'd200, 8'd3, 2'b00, 0, 1);
        tick();
        st[1] = 1'b0;
        wait_done(1, 12);
        pin("mul200x3", 1, 8'h58, 8'h02, 6'b010001);
        drive(1, 1, 8'h00, 8'hFF, 2'b00, 0, 1);
        tick();
        st[1] = 1'b0;
        wait_done(1, 12);
        pin("mul0", 1, 8'h00, 8'h00, 6'b100001);
        drive(1, 1, 8'h80, 8'h01, 2'b01, 0, 0);
        tick();
        pin("sub_ovf", 1, 8'h7F, 8'h00, 6'b011001);
        drive(1, 1, 8'h7F, 8'h01, 2'b00, 0, 0);
        tick();
        pin("add_ovf", 1, 8'h80, 8'h00, 6'b001101);
        st[1] = 1'b0;
        tick();

        // random traffic on both instances
        repeat (400) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0);
            end
            tick();
        end
        st = 2'b00;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
